// File: rtl/hardtanh_pipe.sv
`default_nettype none
// ============================================================================
// Module      : hardtanh_pipe
// Description : Two-stage streaming HardTanh. Stage 1 clamps each lane to the
//               per-tensor bounds [cfg_min, cfg_max] latched on beat 0 and
//               counts clamped lanes. Stage 2 requantises from the input
//               fixed-point format to the output format with round-half-up
//               and signed saturation.
// Ports       : clk, rst (async, active-low)
//               cfg_min / cfg_max           - signed bounds, input format
//               data_in_0 / _valid / _ready - lane-packed input stream
//               data_out_0 / _valid / _ready / _last - lane-packed output stream
//               sat_count                   - clamped elements of last tensor
// Revision    : 1.0 - initial release
// ============================================================================
module hardtanh_pipe #(
    parameter int DATA_IN_0_PRECISION_0       = 8,
    parameter int DATA_IN_0_PRECISION_1       = 4,
    parameter int DATA_OUT_0_PRECISION_0      = 8,
    parameter int DATA_OUT_0_PRECISION_1      = 4,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 8,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0] cfg_min,
    input  logic [DATA_IN_0_PRECISION_0-1:0] cfg_max,
    input  logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1*DATA_IN_0_PRECISION_0-1:0] data_in_0,
    input  logic data_in_0_valid,
    output logic data_in_0_ready,
    output logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1*DATA_OUT_0_PRECISION_0-1:0] data_out_0,
    output logic data_out_0_valid,
    input  logic data_out_0_ready,
    output logic data_out_0_last,
    output logic [$clog2(DATA_IN_0_TENSOR_SIZE_DIM_0*DATA_IN_0_TENSOR_SIZE_DIM_1+1)-1:0] sat_count
);

    localparam int IN_W      = DATA_IN_0_PRECISION_0;
    localparam int OUT_W     = DATA_OUT_0_PRECISION_0;
    localparam int N         = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
    localparam int B         = (DATA_IN_0_TENSOR_SIZE_DIM_0 / DATA_IN_0_PARALLELISM_DIM_0) *
                               (DATA_IN_0_TENSOR_SIZE_DIM_1 / DATA_IN_0_PARALLELISM_DIM_1);
    localparam int TOTAL     = DATA_IN_0_TENSOR_SIZE_DIM_0 * DATA_IN_0_TENSOR_SIZE_DIM_1;
    localparam int SAT_W     = $clog2(TOTAL + 1);
    localparam int BEAT_W    = (B > 1) ? $clog2(B) : 1;
    localparam int SHIFT     = DATA_IN_0_PRECISION_1 - DATA_OUT_0_PRECISION_1;
    localparam int ABS_SHIFT = (SHIFT < 0) ? -SHIFT : SHIFT;
    // Wide enough for the shifted value, the rounding add and the OUT_W limits.
    localparam int WIDE_W    = (((IN_W + ABS_SHIFT) > OUT_W) ? (IN_W + ABS_SHIFT) : OUT_W) + 2;

    localparam logic [BEAT_W-1:0]        LAST_BEAT = BEAT_W'(B - 1);
    localparam logic signed [WIDE_W-1:0] OUT_MAX   = (WIDE_W'(1) << (OUT_W - 1)) - WIDE_W'(1);
    localparam logic signed [WIDE_W-1:0] OUT_MIN   = ~OUT_MAX;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [BEAT_W-1:0]     in_cnt_q,   in_cnt_d;
    logic [BEAT_W-1:0]     out_cnt_q,  out_cnt_d;
    logic [IN_W-1:0]       min_q,      min_d;
    logic [IN_W-1:0]       max_q,      max_d;
    logic [SAT_W-1:0]      acc_q,      acc_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [N*IN_W-1:0]     s1_data_q,  s1_data_d;
    logic [SAT_W-1:0]      s1_total_q, s1_total_d;
    logic                  s2_valid_q, s2_valid_d;
    logic [N*OUT_W-1:0]    s2_data_q,  s2_data_d;
    logic [SAT_W-1:0]      s2_total_q, s2_total_d;
    logic [SAT_W-1:0]      sat_q,      sat_d;

    // ------------------------------------------------------------------------
    // Handshake: a stage may load when its successor is empty or draining.
    // ------------------------------------------------------------------------
    logic w_s2_adv, w_s1_adv, w_accept, w_out_fire, w_first;

    assign w_s2_adv   = !s2_valid_q || data_out_0_ready;
    assign w_s1_adv   = !s1_valid_q || w_s2_adv;
    assign w_accept   = data_in_0_valid && w_s1_adv;
    assign w_out_fire = s2_valid_q && data_out_0_ready;
    assign w_first    = (in_cnt_q == '0);

    // rst only gates the visible ready; internal flops are held by reset anyway.
    assign data_in_0_ready  = rst && w_s1_adv;
    assign data_out_0       = s2_data_q;
    assign data_out_0_valid = s2_valid_q;
    assign data_out_0_last  = s2_valid_q && (out_cnt_q == LAST_BEAT);
    assign sat_count        = sat_q;

    // Beat 0 uses the live bounds; later beats use the copy latched on beat 0.
    logic signed [IN_W-1:0] w_lo, w_hi;
    assign w_lo = w_first ? cfg_min : min_q;
    assign w_hi = w_first ? cfg_max : max_q;

    // ------------------------------------------------------------------------
    // Stage 1 combinational: clamp and saturation flags per lane
    // ------------------------------------------------------------------------
    logic [N*IN_W-1:0] w_clamp;
    logic [N-1:0]      w_lane_sat;
    logic [SAT_W-1:0]  w_beat_sat;

    for (genvar l = 0; l < N; l++) begin : g_clamp
        logic signed [IN_W-1:0] w_x;
        assign w_x = data_in_0[l*IN_W +: IN_W];
        assign w_lane_sat[l] = (w_x < w_lo) || (w_x > w_hi);
        // With inverted bounds min(max(x,lo),hi) collapses to hi.
        assign w_clamp[l*IN_W +: IN_W] = (w_lo > w_hi) ? w_hi :
                                         (w_x < w_lo)  ? w_lo :
                                         (w_x > w_hi)  ? w_hi : w_x;
    end

    always_comb begin
        w_beat_sat = '0;
        for (int l = 0; l < N; l++) begin
            w_beat_sat = w_beat_sat + SAT_W'(w_lane_sat[l]);
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2 combinational: requantise and saturate per lane
    // ------------------------------------------------------------------------
    logic [N*OUT_W-1:0] w_req;

    for (genvar l = 0; l < N; l++) begin : g_req
        logic signed [WIDE_W-1:0] w_ext;
        logic signed [WIDE_W-1:0] w_scaled;
        logic [IN_W-1:0]          w_y;

        assign w_y   = s1_data_q[l*IN_W +: IN_W];
        assign w_ext = {{(WIDE_W-IN_W){w_y[IN_W-1]}}, w_y};

        if (SHIFT > 0) begin : g_rnd
            localparam logic signed [WIDE_W-1:0] HALF = WIDE_W'(1) << (SHIFT - 1);
            logic signed [WIDE_W-1:0] w_sum;
            assign w_sum    = w_ext + HALF;
            assign w_scaled = w_sum >>> SHIFT;
        end else if (SHIFT < 0) begin : g_shl
            assign w_scaled = w_ext <<< ABS_SHIFT;
        end else begin : g_pass
            assign w_scaled = w_ext;
        end

        assign w_req[l*OUT_W +: OUT_W] = (w_scaled > OUT_MAX) ? OUT_MAX[OUT_W-1:0] :
                                         (w_scaled < OUT_MIN) ? OUT_MIN[OUT_W-1:0] :
                                         w_scaled[OUT_W-1:0];
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        in_cnt_d   = in_cnt_q;
        out_cnt_d  = out_cnt_q;
        min_d      = min_q;
        max_d      = max_q;
        acc_d      = acc_q;
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_total_d = s1_total_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_total_d = s2_total_q;
        sat_d      = sat_q;

        if (w_accept) begin
            in_cnt_d = (in_cnt_q == LAST_BEAT) ? '0 : in_cnt_q + BEAT_W'(1);
            if (w_first) begin
                min_d = cfg_min;
                max_d = cfg_max;
            end
            // The running total travels with each beat; only the last beat's
            // copy is ever loaded into sat_count. The accumulator restarts
            // as soon as the last beat is in, so the next tensor starts clean.
            acc_d = (in_cnt_q == LAST_BEAT) ? '0 : acc_q + w_beat_sat;
        end

        if (w_s1_adv) begin
            s1_valid_d = w_accept;
            if (w_accept) begin
                s1_data_d  = w_clamp;
                s1_total_d = acc_q + w_beat_sat;
            end
        end

        if (w_s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d  = w_req;
                s2_total_d = s1_total_q;
            end
        end

        if (w_out_fire) begin
            out_cnt_d = (out_cnt_q == LAST_BEAT) ? '0 : out_cnt_q + BEAT_W'(1);
            if (out_cnt_q == LAST_BEAT) begin
                sat_d = s2_total_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            min_q      <= '0;
            max_q      <= '0;
            acc_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_total_q <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_total_q <= '0;
            sat_q      <= '0;
        end else begin
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            min_q      <= min_d;
            max_q      <= max_d;
            acc_q      <= acc_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_total_q <= s1_total_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_total_q <= s2_total_d;
            sat_q      <= sat_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/hardtanh_pipe.md
HARDTANH_PIPE -- requirements
Module: hardtanh_pipe

Interface
REQ-001 Parameter DATA_IN_0_PRECISION_0, default 8: input word width in bits, signed fixed point.
REQ-002 Parameter DATA_IN_0_PRECISION_1, default 4: input fractional bits.
REQ-003 Parameter DATA_OUT_0_PRECISION_0, default 8: output word width in bits, signed.
REQ-004 Parameter DATA_OUT_0_PRECISION_1, default 4: output fractional bits.
REQ-005 Parameters DATA_IN_0_TENSOR_SIZE_DIM_0 / _DIM_1, defaults 8 / 1: tensor size.
REQ-006 Parameters DATA_IN_0_PARALLELISM_DIM_0 / _DIM_1, defaults 1 / 1: lanes per beat. N = DIM_0 * DIM_1; both dimensions divide the tensor size exactly.
REQ-007 clk  input  1  sole clock; all logic is rising-edge.
REQ-008 rst  input  1  asynchronous, active-low reset.
REQ-009 cfg_min  input  IN_W  signed lower bound, input format.
REQ-010 cfg_max  input  IN_W  signed upper bound, input format.
REQ-011 data_in_0  input  N*IN_W  lane-packed input; lane 0 in the LSBs.
REQ-012 data_in_0_valid / data_in_0_ready  input / output  1  input handshake.
REQ-013 data_out_0  output  N*OUT_W  lane-packed result.
REQ-014 data_out_0_valid / data_out_0_ready  output / input  1  output handshake.
REQ-015 data_out_0_last  output  1  marks the final beat of a tensor.
REQ-016 sat_count  output  clog2(TENSOR_SIZE_DIM_0 * TENSOR_SIZE_DIM_1 + 1)  number of clamped elements in the last completed tensor.

Function
REQ-017 A transfer SHALL occur only on a clock edge where valid and ready are both high. Data and valid SHALL stay stable while valid is high and ready is low.
REQ-018 Beats per tensor B = (TS0 / P0) * (TS1 / P1). The input beat counter SHALL wrap from B-1 to 0. The output beat counter SHALL do the same, and data_out_0_last = 1 when it equals B-1.
REQ-019 cfg_min and cfg_max SHALL be sampled only when beat 0 of a tensor is accepted, and held for the whole tensor. Changes mid-tensor SHALL be ignored.
REQ-020 Stage 1 clamp, per lane: y = min(max(x, cfg_min), cfg_max). If cfg_min > cfg_max, every lane SHALL output cfg_max.
REQ-021 A lane SHALL count as saturated when x < cfg_min or x > cfg_max. Values exactly equal to a bound SHALL NOT count.
REQ-022 Stage 2 requantise with s = IN_FRAC - OUT_FRAC.
  - s > 0: add 2^(s-1), then arithmetic right shift by s (round half up).
  - s < 0: left shift by -s.
  - s = 0: pass through.
  - Then saturate to the signed OUT_W range, using full-width intermediates.
REQ-023 Latency SHALL be exactly 2 cycles from input acceptance to data_out_0_valid when there is no backpressure. Throughput SHALL be 1 beat per cycle.
REQ-024 Each stage SHALL advance when its successor is empty or is transferring this cycle.
  - data_in_0_ready = !s1_valid | !s2_valid | data_out_0_ready.
  - No beat SHALL be lost or duplicated, and order SHALL be preserved.
REQ-025 A per-tensor saturation accumulator SHALL add each beat's saturated-lane count at stage 1.
  - On the transfer of a last beat, sat_count SHALL load the final total, which includes that beat.
  - sat_count SHALL hold until the next last-beat transfer, and the accumulator SHALL clear.
REQ-026 If a beat enters stage 1 on the same cycle a last beat leaves, the new beat's count SHALL start the fresh accumulation.

Reset
REQ-027 While rst = 0, all of the following SHALL be cleared asynchronously:
  - data_out_0_valid, data_out_0, data_out_0_last, sat_count, both beat counters, the accumulator, the stage valids and the latched bounds (all to 0);
  - data_in_0_ready SHALL be 0.
REQ-028 After rst deasserts, data_in_0_ready SHALL be 1 on the first cycle, and the next accepted beat SHALL be beat 0.
REQ-029 Reset mid-tensor SHALL discard all in-flight beats and partial counts.

Verification
REQ-030 Setup: IN 8/4, OUT 8/4, cfg_min = 0xF0, cfg_max = 0x10. Send 0x7F, 0x80, 0x08, 0x10 -> outputs 0x10, 0xF0, 0x08, 0x10, each 2 cycles after acceptance.
REQ-031 Setup: OUT 8/2, input 0x0A within bounds -> 0x03. Input 0x06 -> 0x02 (round half up).
REQ-032 Continuous input with data_out_0_ready low for 5 cycles -> data_in_0_ready drops after 2 buffered beats. The release yields every beat in order, with none lost.
REQ-033 Change cfg_max to 0x20 at beat 3 of an 8-beat tensor -> beats 3..7 are still clamped at 0x10. The next tensor clamps at 0x20.
REQ-034 8-beat tensor with 3 inputs out of range, one exactly 0x10 -> data_out_0_last on beat 7, and sat_count = 3 from that cycle onward.
REQ-035 Assert rst low with 2 beats in flight -> valid and last drop immediately, sat_count = 0, and the next tensor restarts at beat 0.
